inert_intf: RTL

- Producer end of the pitch interface consumed by the balance controller: drives ptch, ptch_rt, vld from the IMU.
- Sequences IMU configuration writes after reset, then on each IMU data-ready interrupt reads pitch-rate and Z-accel registers through the existing SPI monarch handshake (wrt/cmd/done/rd_data).
- Integrates compensated pitch rate into ptch via a sub-module.

---
 rtl/segway_pkg.sv | 48 ++++
 rtl/inert_intf_if.sv | 10 +
 rtl/inert_intf_integrator.sv | 30 +++
 rtl/inert_intf.sv | 111 +++++++++++
 4 files changed

// File: rtl/segway_pkg.sv
// rtl/segway_pkg.sv - shared states, IMU command words and pitch-rate offset for the inertial interface
package segway_pkg;

    typedef enum logic [3:0] {
        INIT_WAIT,
        CFG0,
        CFG1,
        CFG2,
        CFG3,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        UPDATE,
        VLD
    } inert_state_t;

    localparam logic [15:0] CFG_INT   = 16'h0D02;
    localparam logic [15:0] CFG_ACCEL = 16'h1053;
    localparam logic [15:0] CFG_GYRO  = 16'h1150;
    localparam logic [15:0] CFG_ROUND = 16'h1460;
    localparam logic [15:0] RD_PTCHL  = 16'hA200;
    localparam logic [15:0] RD_PTCHH  = 16'hA300;
    localparam logic [15:0] RD_AZL    = 16'hAC00;
    localparam logic [15:0] RD_AZH    = 16'hAD00;

    localparam logic [15:0] PTCH_RT_OFFSET = 16'h0050;

    function automatic logic [15:0] state_cmd(input inert_state_t s);
        case (s)
            CFG0:    return CFG_INT;
            CFG1:    return CFG_ACCEL;
            CFG2:    return CFG_GYRO;
            CFG3:    return CFG_ROUND;
            RD_PL:   return RD_PTCHL;
            RD_PH:   return RD_PTCHH;
            RD_AL:   return RD_AZL;
            RD_AH:   return RD_AZH;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic is_xfer_state(input inert_state_t s);
        return (s inside {CFG0, CFG1, CFG2, CFG3, RD_PL, RD_PH, RD_AL, RD_AH});
    endfunction

endpackage

// File: rtl/inert_intf_if.sv
// rtl/inert_intf_if.sv - SPI monarch handshake between the inertial interface and the SPI engine
interface inert_intf_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

// File: rtl/inert_intf_integrator.sv
// rtl/inert_intf_integrator.sv - offset-compensated pitch-rate integrator producing ptch
module inertial_integrator
    import segway_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               step,
    input  logic signed [15:0] ptch_rt,
    output logic signed [15:0] ptch
);

    logic [15:0] ptch_rt_comp;
    logic [26:0] ptch_int;
    logic [26:0] ptch_int_nxt;

    assign ptch_rt_comp = ptch_rt - PTCH_RT_OFFSET;
    assign ptch_int_nxt = ptch_int - {{11{ptch_rt_comp[15]}}, ptch_rt_comp};

    // ptch is loaded from the next accumulator value so it is valid the cycle after step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptch_int <= '0;
            ptch     <= '0;
        end else if (step) begin
            ptch_int <= ptch_int_nxt;
            ptch     <= ptch_int_nxt[26:11];
        end
    end

endmodule

// File: rtl/inert_intf.sv
// rtl/inert_intf.sv - IMU configuration/read sequencer driving ptch, ptch_rt, az and vld
module inert_intf
    import segway_pkg::*;
#(
    parameter logic fast_sim = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               INT,
    inert_intf_if.master       spi,
    output logic signed [15:0] ptch_rt,
    output logic signed [15:0] az,
    output logic signed [15:0] ptch,
    output logic               vld
);

    localparam logic [15:0] INIT_TERM = fast_sim ? 16'd1023 : 16'hFFFF;

    inert_state_t state, nxt_state;
    logic [15:0]  timer;
    logic [2:0]   int_ff;
    logic         int_rise;
    logic         xfer_done;
    logic         start_xfer;
    logic         step;
    logic [7:0]   pl, ph, al, ah;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) int_ff <= '0;
        else        int_ff <= {int_ff[1:0], INT};
    end

    assign int_rise = int_ff[1] & ~int_ff[2];

    // done in the same cycle as wrt belongs to the previous transaction, so it is ignored
    assign xfer_done = spi.done & ~spi.wrt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT_WAIT;
        else        state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        step      = 1'b0;
        case (state)
            INIT_WAIT: if (timer == INIT_TERM) nxt_state = CFG0;
            CFG0:      if (xfer_done) nxt_state = CFG1;
            CFG1:      if (xfer_done) nxt_state = CFG2;
            CFG2:      if (xfer_done) nxt_state = CFG3;
            CFG3:      if (xfer_done) nxt_state = WAIT_INT;
            WAIT_INT:  if (int_rise)  nxt_state = RD_PL;
            RD_PL:     if (xfer_done) nxt_state = RD_PH;
            RD_PH:     if (xfer_done) nxt_state = RD_AL;
            RD_AL:     if (xfer_done) nxt_state = RD_AH;
            RD_AH:     if (xfer_done) nxt_state = UPDATE;
            UPDATE: begin
                step      = 1'b1;
                nxt_state = VLD;
            end
            VLD:       nxt_state = WAIT_INT;
            default:   nxt_state = INIT_WAIT;
        endcase
    end

    assign start_xfer = (nxt_state != state) && is_xfer_state(nxt_state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            spi.wrt <= 1'b0;
            spi.cmd <= '0;
            vld     <= 1'b0;
            ptch_rt <= '0;
            az      <= '0;
            pl      <= '0;
            ph      <= '0;
            al      <= '0;
            ah      <= '0;
        end else begin
            spi.wrt <= start_xfer;
            vld     <= (nxt_state == VLD);
            if (start_xfer)
                spi.cmd <= state_cmd(nxt_state);
            if (state == INIT_WAIT)
                timer <= timer + 16'd1;
            if (xfer_done) begin
                case (state)
                    RD_PL:   pl <= spi.rd_data[7:0];
                    RD_PH:   ph <= spi.rd_data[7:0];
                    RD_AL:   al <= spi.rd_data[7:0];
                    RD_AH:   ah <= spi.rd_data[7:0];
                    default: ;
                endcase
            end
            if (step) begin
                ptch_rt <= {ph, pl};
                az      <= {ah, al};
            end
        end
    end

    inertial_integrator u_integrator (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (step),
        .ptch_rt ({ph, pl}),
        .ptch    (ptch)
    );

endmodule
